// File: rtl/cam_grid_avg.sv
// cam_grid_avg: reassembles the RGB565 byte stream from the camera FIFO into
// pixels and accumulates per-channel sums for the nine cells of a fixed 3x3
// grid. The per-cell averages and a status word are readable over Wishbone.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   frame_start              one-cycle start-of-frame pulse
//   pix_byte, pix_valid      FIFO byte stream (high byte first)
//   wb_adr_i .. wb_ack_o     Wishbone slave, word index = wb_adr_i[5:2]
//   done                     a completed frame's results are held
module cam_grid_avg #(
    parameter int unsigned IMG_W     = 160,
    parameter int unsigned IMG_H     = 120,
    parameter int unsigned X0        = 32,
    parameter int unsigned Y0        = 12,
    parameter int unsigned CELL_LOG2 = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic [7:0]  pix_byte,
    input  logic        pix_valid,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic [3:0]  wb_sel_i,
    output logic        wb_ack_o,
    output logic        done
);

    localparam int unsigned XW = $clog2(IMG_W);
    localparam int unsigned YW = $clog2(IMG_H);
    localparam int unsigned CS = 1 << CELL_LOG2;
    localparam int unsigned AW = 6 + 2 * CELL_LOG2;
    localparam int unsigned SH = 2 * CELL_LOG2;

    localparam logic [XW-1:0] X_LO   = XW'(X0);
    localparam logic [XW-1:0] X_HI   = XW'(X0 + 3 * CS);
    localparam logic [YW-1:0] Y_LO   = YW'(Y0);
    localparam logic [YW-1:0] Y_HI   = YW'(Y0 + 3 * CS);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPT, S_DONE} state_t;

    state_t        state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          phase;
    logic [7:0]    hi_byte;
    logic [15:0]   frame_count;
    logic [AW-1:0] acc_r [0:8];
    logic [AW-1:0] acc_g [0:8];
    logic [AW-1:0] acc_b [0:8];

    logic          wb_hit_c, arm_c, clr_c, pix_done_c, acc_en_c, in_grid_c, last_px_c;
    logic [4:0]    r_c, b_c;
    logic [5:0]    g_c;
    logic [XW-1:0] dx_c;
    logic [YW-1:0] dy_c;
    logic [3:0]    cell_c;
    logic [31:0]   rd_c;
    logic          unused_ok;

    assign unused_ok = &{1'b0, wb_sel_i, wb_dat_i[31:1], wb_adr_i[31:6], wb_adr_i[1:0]};

    // Pixel assembly, grid decode and control strobes
    always_comb begin
        r_c        = hi_byte[7:3];
        g_c        = {hi_byte[2:0], pix_byte[7:5]};
        b_c        = pix_byte[4:0];
        dx_c       = x - X_LO;
        dy_c       = y - Y_LO;
        in_grid_c  = (x >= X_LO) && (x < X_HI) && (y >= Y_LO) && (y < Y_HI);
        cell_c     = 4'(dy_c >> CELL_LOG2) * 4'd3 + 4'(dx_c >> CELL_LOG2);
        last_px_c  = (x == X_LAST) && (y == Y_LAST);
        wb_hit_c   = wb_cyc_i & wb_stb_i & ~wb_ack_o;
        arm_c      = wb_hit_c & wb_we_i & (wb_adr_i[5:2] == 4'd10) & wb_dat_i[0];
        // a byte coincident with frame_start is dropped
        pix_done_c = (state == S_CAPT) & pix_valid & ~frame_start & phase;
        acc_en_c   = pix_done_c & in_grid_c;
        clr_c      = (((state == S_IDLE) || (state == S_DONE)) && arm_c) ||
                     ((state == S_CAPT) && frame_start);
    end

    // Register read mux
    always_comb begin
        logic [AW-1:0] ra, ga, ba;
        ra   = '0;
        ga   = '0;
        ba   = '0;
        rd_c = '0;
        for (int i = 0; i < 9; i++) begin
            if (wb_adr_i[5:2] == 4'(i)) begin
                ra   = acc_r[i] >> SH;
                ga   = acc_g[i] >> SH;
                ba   = acc_b[i] >> SH;
                rd_c = {16'h0, ra[4:0], ga[5:0], ba[4:0]};
            end
        end
        if (wb_adr_i[5:2] == 4'd9) begin
            rd_c = {frame_count, 14'h0, (state == S_WAIT) || (state == S_CAPT), done};
        end
    end

    // Per-cell channel accumulators
    always_ff @(posedge clk) begin
        for (int i = 0; i < 9; i++) begin
            if (rst || clr_c) begin
                acc_r[i] <= '0;
                acc_g[i] <= '0;
                acc_b[i] <= '0;
            end else if (acc_en_c && (cell_c == 4'(i))) begin
                acc_r[i] <= acc_r[i] + AW'(r_c);
                acc_g[i] <= acc_g[i] + AW'(g_c);
                acc_b[i] <= acc_b[i] + AW'(b_c);
            end
        end
    end

    // Capture FSM, pixel counters and Wishbone response
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            x           <= '0;
            y           <= '0;
            phase       <= 1'b0;
            hi_byte     <= '0;
            frame_count <= '0;
            done        <= 1'b0;
            wb_ack_o    <= 1'b0;
            wb_dat_o    <= '0;
        end else begin
            wb_ack_o <= wb_hit_c;
            if (wb_hit_c) begin
                wb_dat_o <= rd_c;
            end
            case (state)
                S_IDLE: begin
                    if (arm_c) state <= S_WAIT;
                end
                S_WAIT: begin
                    if (frame_start) begin
                        state <= S_CAPT;
                        x     <= '0;
                        y     <= '0;
                        phase <= 1'b0;
                    end
                end
                S_CAPT: begin
                    if (frame_start) begin
                        x     <= '0;
                        y     <= '0;
                        phase <= 1'b0;
                    end else if (pix_valid) begin
                        phase <= ~phase;
                        if (!phase) begin
                            hi_byte <= pix_byte;
                        end else begin
                            if (x == X_LAST) begin
                                x <= '0;
                                y <= (y == Y_LAST) ? '0 : y + YW'(1);
                            end else begin
                                x <= x + XW'(1);
                            end
                            if (last_px_c) begin
                                state       <= S_DONE;
                                done        <= 1'b1;
                                frame_count <= frame_count + 16'd1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (arm_c) begin
                        state <= S_WAIT;
                        done  <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
